cart_to_polar: RTL

Converts one frame of complex FFT bins (Q1.15 real/imag) into magnitude and phase using an iterative vectoring CORDIC. Results are written into the ping-pong pre-scaler magnitude/phase buffers. Sits between the forward-FFT output buffer and `scaler`. It hands off each finished frame with a one-cycle `go_out` pulse and reports via `cur_window` which buffer holds the newest frame.

---
 rtl/cart_to_polar.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cart_to_polar.sv
// cart_to_polar
// Converts one frame of complex FFT bins (Q1.15 real/imag) into magnitude and
// phase using an iterative vectoring CORDIC, writing results into a ping-pong
// pair of magnitude/phase buffers. Each finished frame is handed off with a
// one-cycle go_out pulse, and cur_window names the pair holding it.
//
// Ports:
//   clk, reset               system clock, asynchronous active-high reset
//   go_in                    start-of-frame strobe, honoured only while idle
//   fft_real_data/imag_data  Q1.15 bin data, one-cycle synchronous read latency
//   fft_raddr                bin read address for both FFT ports
//   mag_wrdata               unsigned magnitude, LSB = 2^-15
//   phase_wrdata             signed Q8.8 radians, clamped to +/-804
//   wraddr                   bin write address shared by all four buffers
//   mag/phase_buf_0/1_wren   write enables for buffer pair 0 / pair 1
//   busy                     high while a frame is in progress
//   cur_window               pair holding the most recent complete frame
//   go_out                   one-cycle frame-complete pulse
module cart_to_polar #(
  parameter int N_BINS = 1024,
  parameter int ITER   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go_in,
  input  logic [15:0] fft_real_data,
  input  logic [15:0] fft_imag_data,
  output logic [11:0] fft_raddr,
  output logic [15:0] mag_wrdata,
  output logic [15:0] phase_wrdata,
  output logic [11:0] wraddr,
  output logic        mag_buf_0_wren,
  output logic        phase_buf_0_wren,
  output logic        mag_buf_1_wren,
  output logic        phase_buf_1_wren,
  output logic        busy,
  output logic        cur_window,
  output logic        go_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_ITER, S_SCALE, S_WRITE, S_DONE
  } state_t;

  localparam logic [11:0]        LAST_ADDR = 12'(N_BINS - 1);
  localparam logic [3:0]         LAST_ITER = 4'(ITER - 1);
  localparam logic signed [17:0] PI_Q412   = 18'sd12868;
  // 1/CORDIC gain (0.60725) in Q0.16
  localparam logic signed [35:0] INV_GAIN  = 36'sd39797;
  localparam logic [17:0]        PHASE_MAX = 18'd804;

  state_t state, state_next;

  logic signed [17:0] x, y, z;
  logic [3:0]         iter_cnt;
  logic               zero_in;
  logic               wr_buf;

  logic signed [17:0] re_ext, im_ext, x_shr, y_shr, atan_k;
  logic signed [35:0] mag_prod, mag_round;
  logic [15:0]        mag_sat;
  logic [17:0]        z_abs, ph_abs;
  logic [15:0]        ph_lim, phase_val;
  logic               last_bin;

  // atan(2^-k) in Q4.12
  function automatic logic signed [17:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    atan_lut = 18'sd3217;
      4'd1:    atan_lut = 18'sd1899;
      4'd2:    atan_lut = 18'sd1003;
      4'd3:    atan_lut = 18'sd509;
      4'd4:    atan_lut = 18'sd256;
      4'd5:    atan_lut = 18'sd128;
      4'd6:    atan_lut = 18'sd64;
      4'd7:    atan_lut = 18'sd32;
      4'd8:    atan_lut = 18'sd16;
      4'd9:    atan_lut = 18'sd8;
      4'd10:   atan_lut = 18'sd4;
      4'd11:   atan_lut = 18'sd2;
      4'd12:   atan_lut = 18'sd1;
      default: atan_lut = 18'sd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (go_in) state_next = S_READ;
      S_READ:  state_next = S_LOAD;
      S_LOAD:  state_next = S_ITER;
      S_ITER:  if (iter_cnt == LAST_ITER) state_next = S_SCALE;
      S_SCALE: state_next = S_WRITE;
      S_WRITE: state_next = last_bin ? S_DONE : S_READ;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    go_out = (state == S_DONE);
  end

  // Shared arithmetic: micro-rotation operands and the SCALE-stage conversion
  // of the converged x/z into the output formats.
  always_comb begin
    re_ext   = {{2{fft_real_data[15]}}, fft_real_data};
    im_ext   = {{2{fft_imag_data[15]}}, fft_imag_data};
    x_shr    = x >>> iter_cnt;
    y_shr    = y >>> iter_cnt;
    atan_k   = atan_lut(iter_cnt);
    last_bin = (fft_raddr == LAST_ADDR);

    mag_prod  = $signed({{18{x[17]}}, x}) * INV_GAIN;
    mag_round = (mag_prod + 36'sd32768) >>> 16;
    if (mag_prod < 0)                  mag_sat = 16'd0;
    else if (mag_round > 36'sd65535)   mag_sat = 16'hFFFF;
    else                               mag_sat = mag_round[15:0];

    // Round the Q4.12 angle to Q8.8 on its magnitude so that halves move
    // away from zero, then restore the sign.
    z_abs     = z[17] ? -z : z;
    ph_abs    = (z_abs + 18'd8) >> 4;
    ph_lim    = (ph_abs > PHASE_MAX) ? 16'd804 : ph_abs[15:0];
    phase_val = z[17] ? (16'd0 - ph_lim) : ph_lim;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x                <= '0;
      y                <= '0;
      z                <= '0;
      iter_cnt         <= '0;
      zero_in          <= 1'b0;
      wr_buf           <= 1'b0;
      cur_window       <= 1'b0;
      fft_raddr        <= '0;
      wraddr           <= '0;
      mag_wrdata       <= '0;
      phase_wrdata     <= '0;
      mag_buf_0_wren   <= 1'b0;
      phase_buf_0_wren <= 1'b0;
      mag_buf_1_wren   <= 1'b0;
      phase_buf_1_wren <= 1'b0;
    end else begin
      case (state)
        S_IDLE: fft_raddr <= '0;
        S_LOAD: begin
          iter_cnt <= '0;
          zero_in  <= (fft_real_data == 16'd0) && (fft_imag_data == 16'd0);
          // Left half-plane: rotate by pi so the CORDIC starts with x >= 0.
          if (!re_ext[17]) begin
            x <= re_ext;
            y <= im_ext;
            z <= '0;
          end else begin
            x <= -re_ext;
            y <= -im_ext;
            z <= im_ext[17] ? -PI_Q412 : PI_Q412;
          end
        end
        S_ITER: begin
          if (!y[17]) begin
            x <= x + y_shr;
            y <= y - x_shr;
            z <= z + atan_k;
          end else begin
            x <= x - y_shr;
            y <= y + x_shr;
            z <= z - atan_k;
          end
          iter_cnt <= iter_cnt + 4'd1;
        end
        S_SCALE: begin
          mag_wrdata       <= zero_in ? 16'd0 : mag_sat;
          phase_wrdata     <= zero_in ? 16'd0 : phase_val;
          wraddr           <= fft_raddr;
          mag_buf_0_wren   <= ~wr_buf;
          phase_buf_0_wren <= ~wr_buf;
          mag_buf_1_wren   <= wr_buf;
          phase_buf_1_wren <= wr_buf;
        end
        S_WRITE: begin
          mag_buf_0_wren   <= 1'b0;
          phase_buf_0_wren <= 1'b0;
          mag_buf_1_wren   <= 1'b0;
          phase_buf_1_wren <= 1'b0;
          if (!last_bin) fft_raddr <= fft_raddr + 12'd1;
        end
        S_DONE: begin
          cur_window <= wr_buf;
          wr_buf     <= ~wr_buf;
          fft_raddr  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
